// File: rtl/fetch_unit_if.sv
// Instruction-bus request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
`timescale 1ns/1ps
interface fetch_unit_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );
  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: one outstanding bus fetch, F->D register, decode
// stall and delay-slot redirect. Optional FETCH_ADEL_EN flags misaligned fetches.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       bus,
  input  logic               stall,
  input  logic               ifj,
  input  logic [31:0]        pc_decode,
  output logic               d_valid,
  output logic [31:0]        d_pc,
  output logic [31:0]        d_imp
`ifdef FETCH_ADEL_EN
  ,
  output logic               d_adel
`endif
);

  typedef enum logic [1:0] {S_REQ, S_DATA, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] faddr;
  logic        pend;
  logic [31:0] pend_target;
  logic [31:0] hold_pc;
  logic [31:0] hold_imp;
  logic        misal;
  logic        fetch_done;
  logic        hold_exit;
  logic        take_ifj;
  logic [31:0] fetch_word;

`ifdef FETCH_ADEL_EN
  assign misal = (faddr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign bus.ireq_addr = faddr;
  assign fetch_word    = misal ? '0 : bus.iresp_data;
  assign hold_exit     = (state == S_HOLD) && !stall;
  assign take_ifj      = d_valid && !stall && ifj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  // A misaligned address completes locally in S_REQ without touching the bus.
  always_comb begin
    state_nx       = state;
    bus.ireq_valid = 1'b0;
    fetch_done     = 1'b0;
    case (state)
      S_REQ: begin
        bus.ireq_valid = !misal && !reset;
        if (misal || (bus.iresp_addr_ok && bus.iresp_data_ok)) fetch_done = 1'b1;
        else if (bus.iresp_addr_ok)                              state_nx   = S_DATA;
      end
      S_DATA: begin
        if (bus.iresp_data_ok) fetch_done = 1'b1;
      end
      S_HOLD: begin
        if (!stall) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
    if (fetch_done) state_nx = stall ? S_HOLD : S_REQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      faddr       <= RESET_PC;
      pend        <= 1'b0;
      pend_target <= '0;
      hold_pc     <= '0;
      hold_imp    <= '0;
      d_valid     <= 1'b0;
      d_pc        <= '0;
      d_imp       <= '0;
    end else begin
      // The word in flight or held is the delay slot: redirect lands right after it.
      if (fetch_done) begin
        pend <= 1'b0;
        if (take_ifj)  faddr <= pc_decode;
        else if (pend) faddr <= pend_target;
        else           faddr <= faddr + 32'd4;
        if (stall) begin
          hold_pc  <= faddr;
          hold_imp <= fetch_word;
        end
      end else if (take_ifj) begin
        if (state == S_HOLD) begin
          faddr <= pc_decode;
        end else begin
          pend        <= 1'b1;
          pend_target <= pc_decode;
        end
      end

      if (!stall) begin
        if (fetch_done) begin
          d_valid <= 1'b1;
          d_pc    <= faddr;
          d_imp   <= fetch_word;
        end else if (hold_exit) begin
          d_valid <= 1'b1;
          d_pc    <= hold_pc;
          d_imp   <= hold_imp;
        end else begin
          d_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_ADEL_EN
  logic hold_adel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_adel <= 1'b0;
      d_adel    <= 1'b0;
    end else begin
      if (fetch_done && stall) hold_adel <= misal;
      if (!stall) begin
        if (fetch_done)     d_adel <= misal;
        else if (hold_exit) d_adel <= hold_adel;
      end
    end
  end
`endif

endmodule
